// File: rtl/video_timing_gen.sv
// Parametrised video timing generator with built-in test patterns.
// Counters walk active/front-porch/sync/back-porch; every output is registered one cycle behind them.
module video_timing_gen #(
  parameter int unsigned H_ACT    = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACT    = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DW       = 8,
  parameter int unsigned CW       = 12,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [3*DW-1:0] solid_rgb,
  output logic            vid_de,
  output logic            vid_hs,
  output logic            vid_vs,
  output logic [DW-1:0]   vid_r,
  output logic [DW-1:0]   vid_g,
  output logic [DW-1:0]   vid_b,
  output logic [CW-1:0]   vid_x,
  output logic [CW-1:0]   vid_y,
  output logic            frame_start
);

  localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned BW      = H_ACT / 8;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACT + V_FP + V_SYNC);
  localparam logic [CW-1:0] BW_LAST = CW'((BW == 0) ? 0 : BW - 1);

  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [1:0]      mode_q, mode_eff;
  logic [3*DW-1:0] solid_q, solid_eff;
  logic            at_origin, active, hs_on, vs_on, chk_bit;
  logic [DW-1:0]   pix_r, pix_g, pix_b;

  // Counter and bar-counter next state; the bar counter tracks hcnt so no divider is needed.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d    = '0;
        vcnt_d    = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        if (bar_cnt_q == BW_LAST) begin
          bar_cnt_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end
  end

  // At the origin the live inputs are used so the whole new frame sees the new selection.
  always_comb begin
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    active    = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    hs_on     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs_on     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    chk_bit   = hcnt_q[CHK_LOG2] ^ vcnt_q[CHK_LOG2];
    mode_eff  = at_origin ? mode : mode_q;
    solid_eff = at_origin ? solid_rgb : solid_q;
    pix_r     = '0;
    pix_g     = '0;
    pix_b     = '0;
    unique case (mode_eff)
      2'd0: {pix_r, pix_g, pix_b} = solid_eff;
      2'd1: begin
        pix_r = {DW{~bar_idx_q[1]}};
        pix_g = {DW{~bar_idx_q[2]}};
        pix_b = {DW{~bar_idx_q[0]}};
      end
      2'd2: begin
        pix_r = DW'(hcnt_q);
        pix_g = DW'(hcnt_q);
        pix_b = DW'(hcnt_q);
      end
      2'd3: begin
        pix_r = {DW{chk_bit}};
        pix_g = {DW{chk_bit}};
        pix_b = {DW{chk_bit}};
      end
      default: ;
    endcase
    if (!active) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      mode_q      <= 2'd1;
      solid_q     <= '0;
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      vid_r       <= '0;
      vid_g       <= '0;
      vid_b       <= '0;
      vid_x       <= '0;
      vid_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      if (en) begin
        if (at_origin) begin
          mode_q  <= mode;
          solid_q <= solid_rgb;
        end
        vid_de      <= active;
        vid_hs      <= hs_on ? HS_POL : ~HS_POL;
        vid_vs      <= vs_on ? VS_POL : ~VS_POL;
        vid_r       <= pix_r;
        vid_g       <= pix_g;
        vid_b       <= pix_b;
        vid_x       <= hcnt_q;
        vid_y       <= vcnt_q;
        frame_start <= at_origin;
      end else begin
        // Sync levels and position hold; data path is blanked.
        vid_de      <= 1'b0;
        vid_r       <= '0;
        vid_g       <= '0;
        vid_b       <= '0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 22x8 raster with active-low hsync.
module tb_video_timing_gen;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 12;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [1:0]      mode;
  logic [3*DW-1:0] solid_rgb;
  logic            vid_de, vid_hs, vid_vs, frame_start;
  logic [DW-1:0]   vid_r, vid_g, vid_b;
  logic [CW-1:0]   vid_x, vid_y;

  int checks = 0;
  int failures = 0;
  int ptr = 0;
  logic [23:0] s_rgb [0:511];
  logic        s_de  [0:511];
  logic [23:0] bars  [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .DW(DW), .CW(CW), .CHK_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_x(vid_x), .vid_y(vid_y), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (ptr < 512) begin
      s_rgb[ptr] = {vid_r, vid_g, vid_b};
      s_de[ptr]  = vid_de;
    end
    ptr++;
  endtask

  initial begin
    int n_fs, fs_bad, de_cnt, de_bad, hs_bad, vs_cnt, vs_bad, x_bad, bad, x, y;
    rst = 1'b1; en = 1'b1; mode = 2'd1; solid_rgb = '0;
    repeat (3) @(negedge clk);
    chk("rst_de", vid_de, 0);
    chk("rst_hs", vid_hs, 1);
    chk("rst_vs", vid_vs, 0);
    chk("rst_rgb", {vid_r, vid_g, vid_b}, 0);
    chk("rst_xy", {vid_x, vid_y}, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b0;

    // Two frames of colour bars; sample c shows counter index c.
    n_fs = 0; fs_bad = 0; de_cnt = 0; de_bad = 0; hs_bad = 0; vs_cnt = 0; vs_bad = 0; x_bad = 0;
    ptr = 0;
    for (int c = 0; c < 352; c++) begin
      step();
      x = c % 22;
      y = (c / 22) % 8;
      if (frame_start) n_fs++;
      if (frame_start !== ((c % 176) == 0)) fs_bad++;
      if (vid_de === 1'b1) de_cnt++;
      if (vid_de !== (x < 16 && y < 4)) de_bad++;
      if (vid_hs !== !(x >= 18 && x <= 20)) hs_bad++;
      if (vid_vs === 1'b1) vs_cnt++;
      if (vid_vs !== (y == 5 || y == 6)) vs_bad++;
      if (vid_x !== CW'(x) || vid_y !== CW'(y)) x_bad++;
    end
    chk("fs_count", n_fs, 2);
    chk("fs_position", fs_bad, 0);
    chk("de_count", de_cnt, 128);
    chk("de_position", de_bad, 0);
    chk("hs_position", hs_bad, 0);
    chk("vs_count", vs_cnt, 88);
    chk("vs_position", vs_bad, 0);
    chk("xy_track", x_bad, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("bar_x%0d", i), s_rgb[i], bars[i / 2]);

    // Ramp frame.
    mode = 2'd2; ptr = 0; bad = 0; de_cnt = 0;
    for (int c = 0; c < 176; c++) begin
      step();
      if (vid_de === 1'b1) begin
        de_cnt++;
        if (vid_r !== vid_x[7:0] || vid_g !== vid_x[7:0] || vid_b !== vid_x[7:0]) bad++;
      end
    end
    chk("ramp_match", bad, 0);
    chk("ramp_de", de_cnt, 64);
    chk("ramp_x7", s_rgb[7], 24'h070707);

    // Checker frame.
    mode = 2'd3; ptr = 0;
    repeat (176) step();
    chk("chk_4_0", s_rgb[4], 24'hFFFFFF);
    chk("chk_4_4", {s_de[92], s_rgb[92]}, 25'h0);
    chk("chk_0_0", {s_de[0], s_rgb[0]}, {1'b1, 24'h000000});
    chk("chk_12_3", s_rgb[78], 24'hFFFFFF);
    chk("chk_8_1", s_rgb[30], 24'h000000);

    // Mode change mid-frame lands on the next frame only.
    mode = 2'd1; ptr = 0;
    repeat (27) step();
    mode = 2'd0; solid_rgb = 24'h123456;
    repeat (149) step();
    chk("mid_bar_5_1", s_rgb[27], 24'h00FFFF);
    chk("mid_bar_0_3", s_rgb[66], 24'hFFFFFF);
    chk("mid_bar_9_3", s_rgb[75], 24'hFF00FF);
    ptr = 0; bad = 0; de_cnt = 0;
    for (int c = 0; c < 176; c++) begin
      step();
      if (vid_de === 1'b1) begin
        de_cnt++;
        if ({vid_r, vid_g, vid_b} !== 24'h123456) bad++;
      end
    end
    chk("solid_match", bad, 0);
    chk("solid_de", de_cnt, 64);
    chk("solid_0_0", s_rgb[0], 24'h123456);

    // Enable gap of 10 cycles at x=7 in a ramp frame.
    mode = 2'd2; ptr = 0;
    repeat (7) step();
    en = 1'b0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (vid_de !== 1'b0 || {vid_r, vid_g, vid_b} !== 24'h0 || frame_start !== 1'b0) bad++;
      if (vid_hs !== 1'b1 || vid_vs !== 1'b0 || vid_x !== 12'd6 || vid_y !== 12'd0) bad++;
    end
    chk("gap_outputs", bad, 0);
    en = 1'b1;
    step();
    chk("resume_x", vid_x, 7);
    chk("resume_pix", {vid_de, vid_r, vid_g, vid_b}, {1'b1, 24'h070707});
    n_fs = 0;
    repeat (168) begin
      step();
      if (frame_start === 1'b1) n_fs++;
    end
    chk("gap_no_early_fs", n_fs, 0);
    step();
    chk("gap_fs_186", frame_start, 1);

    // Reset during vsync and hsync (counter index 129: x=19, y=5).
    repeat (129) step();
    chk("pre_rst_sync", {vid_hs, vid_vs}, 2'b01);
    rst = 1'b1;
    step();
    chk("rst_sync_off", {vid_hs, vid_vs}, 2'b10);
    chk("rst_de_off", {vid_de, frame_start}, 2'b00);
    chk("rst_xy_zero", {vid_x, vid_y}, 0);
    rst = 1'b0;
    step();
    chk("rst_fs_follow", {frame_start, vid_de}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
